fadd_far_rsh_sticky_pipe: RTL and testbench

- Parametrised, pipelined far-path alignment unit for the fadd family (fp16/fp32/fp64 via parameters).
- Takes the small operand's significand, the exponent difference, the denormal flag and the effective-subtract flag.
- Produces the right-shifted significand, the lost-bits mask and the sticky bit.
- Sits between exponent compare and the far-path adder; two-stage valid/ready pipeline.

---
 rtl/fadd_pkg.sv | 42 ++++
 rtl/fadd_rsh_mask_gen.sv | 18 +
 rtl/fadd_far_rsh_sticky_pipe.sv | 120 ++++++++++++
 tb/tb_fadd_far_rsh_sticky_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_pkg.sv
// Shared definitions for the fadd far-path alignment slice:
// format presets, shift saturation helper and the S1 payload bundle.
package fadd_pkg;

   localparam int FP16_EXP_W = 5;
   localparam int FP16_SIG_W = 11;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_SIG_W = 24;
   localparam int FP64_EXP_W = 11;
   localparam int FP64_SIG_W = 53;

   // Payload container sized for the widest supported format (fp64
   // needs EXT_W=106, SH_W=7); narrower formats use the low bits.
   localparam int MAX_EXT_W = 128;
   localparam int MAX_SH_W  = 8;

   typedef struct packed {
      logic [MAX_SH_W-1:0]  rsh;
      logic [MAX_EXT_W-1:0] ext;
   } s1_pay_t;

   // Effective right shift: exp_diff less the denormal and
   // pre-shift adjustments, clamped to [0, ext_w].
   function automatic logic [31:0] rsh_sat(
      input logic [31:0] exp_diff,
      input logic        exp_zero,
      input logic        do_sub,
      input logic [31:0] ext_w
   );
      logic [1:0]  adj;
      logic [32:0] raw;
      adj = {1'b0, exp_zero} + {1'b0, do_sub};
      raw = {1'b0, exp_diff} - {31'b0, adj};
      if (raw[32])
         return 32'd0;
      else if (raw[31:0] >= ext_w)
         return ext_w;
      else
         return raw[31:0];
   endfunction

endpackage

// File: rtl/fadd_rsh_mask_gen.sv
// Lost-bits mask generator: mask_o[i] = (i < rsh_i).
// Ports: rsh_i shift amount (0..EXT_W), mask_o EXT_W-bit mask.
module fadd_rsh_mask_gen #(
   parameter int EXT_W = 48,
   parameter int SH_W  = $clog2(EXT_W + 1)
) (
   input  logic [SH_W-1:0]  rsh_i,
   output logic [EXT_W-1:0] mask_o
);

   always_comb begin
      mask_o = '0;
      for (int i = 0; i < EXT_W; i++) begin
         mask_o[i] = (i < int'(rsh_i));
      end
   end

endmodule

// File: rtl/fadd_far_rsh_sticky_pipe.sv
// Two-stage far-path alignment: saturated shift, aligned significand,
// lost-bits mask and sticky. Ports: valid/ready in and out, exp_diff_i,
// exp_zero_i, do_sub_i, sig_small_i -> rsh_amt_o, sig_aligned_o,
// lost_bits_mask_o, sticky_o (all registered).
module fadd_far_rsh_sticky_pipe
   import fadd_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int SIG_W = 24,
   parameter int EXT_W = 2 * SIG_W,
   parameter int SH_W  = $clog2(EXT_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [EXP_W-1:0] exp_diff_i,
   input  logic             exp_zero_i,
   input  logic             do_sub_i,
   input  logic [SIG_W-1:0] sig_small_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [SH_W-1:0]  rsh_amt_o,
   output logic [EXT_W-1:0] sig_aligned_o,
   output logic [EXT_W-1:0] lost_bits_mask_o,
   output logic             sticky_o
);

   logic             s1_valid_d, s1_valid_q;
   logic             s2_valid_d, s2_valid_q;
   s1_pay_t          s1_d, s1_q;
   logic [SH_W-1:0]  rsh_amt_d, rsh_amt_q;
   logic [EXT_W-1:0] sig_aligned_d, sig_aligned_q;
   logic [EXT_W-1:0] mask_d, mask_q;
   logic             sticky_d, sticky_q;

   logic             s1_adv, s2_adv;
   logic [SH_W-1:0]  s1_rsh;
   logic [EXT_W-1:0] s1_ext;
   logic [EXT_W-1:0] s2_mask;
   logic [31:0]      rsh_new;
   logic             unused_pay;

   assign s2_adv     = !s2_valid_q || out_ready_i;
   assign s1_adv     = !s1_valid_q || s2_adv;
   assign in_ready_o = s1_adv;

   assign rsh_new = rsh_sat(32'(exp_diff_i), exp_zero_i,
                            do_sub_i, 32'(EXT_W));

   assign s1_rsh = s1_q.rsh[SH_W-1:0];
   assign s1_ext = s1_q.ext[EXT_W-1:0];
   // High payload bits are constant zero for formats below fp64 width.
   assign unused_pay = ^s1_q;

   fadd_rsh_mask_gen #(
      .EXT_W (EXT_W),
      .SH_W  (SH_W)
   ) u_mask_gen (
      .rsh_i  (s1_rsh),
      .mask_o (s2_mask)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (s1_adv) begin
         s1_valid_d = in_valid_i;
         // Bubbles leave the data registers untouched.
         if (in_valid_i) begin
            s1_d.rsh = MAX_SH_W'(rsh_new);
            s1_d.ext = MAX_EXT_W'({sig_small_i, {(EXT_W-SIG_W){1'b0}}});
         end
      end
   end

   always_comb begin
      s2_valid_d    = s2_valid_q;
      rsh_amt_d     = rsh_amt_q;
      sig_aligned_d = sig_aligned_q;
      mask_d        = mask_q;
      sticky_d      = sticky_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            rsh_amt_d     = s1_rsh;
            sig_aligned_d = s1_ext >> s1_rsh;
            mask_d        = s2_mask;
            sticky_d      = |(s1_ext & s2_mask);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;
         s2_valid_q    <= 1'b0;
         s1_q          <= '0;
         rsh_amt_q     <= '0;
         sig_aligned_q <= '0;
         mask_q        <= '0;
         sticky_q      <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s2_valid_q    <= s2_valid_d;
         s1_q          <= s1_d;
         rsh_amt_q     <= rsh_amt_d;
         sig_aligned_q <= sig_aligned_d;
         mask_q        <= mask_d;
         sticky_q      <= sticky_d;
      end
   end

   assign out_valid_o      = s2_valid_q;
   assign rsh_amt_o        = rsh_amt_q;
   assign sig_aligned_o    = sig_aligned_q;
   assign lost_bits_mask_o = mask_q;
   assign sticky_o         = sticky_q;

endmodule

// File: tb/tb_fadd_far_rsh_sticky_pipe.sv
// Bench for fadd_far_rsh_sticky_pipe (fp32 geometry): reference model
// scoreboard checked every cycle plus hand-computed directed vectors.
module tb_fadd_far_rsh_sticky_pipe;

   localparam int EXP_W = 8;
   localparam int SIG_W = 24;
   localparam int EXT_W = 48;
   localparam int SH_W  = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [EXP_W-1:0] exp_diff_i;
   logic             exp_zero_i;
   logic             do_sub_i;
   logic [SIG_W-1:0] sig_small_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [SH_W-1:0]  rsh_amt_o;
   logic [EXT_W-1:0] sig_aligned_o;
   logic [EXT_W-1:0] lost_bits_mask_o;
   logic             sticky_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;

   typedef struct {
      int          rsh;
      logic [47:0] mask;
      logic [47:0] al;
      logic        st;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   fadd_far_rsh_sticky_pipe #(
      .EXP_W (EXP_W),
      .SIG_W (SIG_W),
      .EXT_W (EXT_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .exp_diff_i       (exp_diff_i),
      .exp_zero_i       (exp_zero_i),
      .do_sub_i         (do_sub_i),
      .sig_small_i      (sig_small_i),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .rsh_amt_o        (rsh_amt_o),
      .sig_aligned_o    (sig_aligned_o),
      .lost_bits_mask_o (lost_bits_mask_o),
      .sticky_o         (sticky_o)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: clamp the adjusted exponent gap, then shift/mask the
   // widened significand arithmetically.
   function automatic exp_t model(input int d, input bit z, input bit s,
                                  input logic [23:0] sg);
      exp_t        e;
      int          r;
      logic [47:0] ext;
      r = d - int'(z) - int'(s);
      if (r < 0)  r = 0;
      if (r > 48) r = 48;
      ext    = {sg, 24'h0};
      e.rsh  = r;
      e.al   = ext >> r;
      e.mask = (r == 48) ? {48{1'b1}} : ((48'd1 << r) - 48'd1);
      e.st   = (ext & e.mask) != 48'd0;
      return e;
   endfunction

   // Scoreboard: inputs are driven just after posedge, so both the
   // handshakes and the outputs are stable at negedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid_o) begin
            if (q.size() == 0) begin
               chk("spurious_out", 64'(out_valid_o), 64'd0);
            end else begin
               chk("sb_rsh", 64'(rsh_amt_o), 64'(q[0].rsh));
               chk("sb_mask", 64'(lost_bits_mask_o), 64'(q[0].mask));
               chk("sb_aligned", 64'(sig_aligned_o), 64'(q[0].al));
               chk("sb_sticky", 64'(sticky_o), 64'(q[0].st));
               if (out_ready_i) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
         end
         if (in_valid_i && in_ready_o)
            q.push_back(model(int'(exp_diff_i), exp_zero_i,
                              do_sub_i, sig_small_i));
      end
   end

   task automatic drive(input int d, input bit z, input bit s,
                        input logic [23:0] sg);
      exp_diff_i  = d[7:0];
      exp_zero_i  = z;
      do_sub_i    = s;
      sig_small_i = sg;
      in_valid_i  = 1'b1;
   endtask

   // Present one input and hold it until accepted (bounded wait).
   task automatic push(input int d, input bit z, input bit s,
                       input logic [23:0] sg);
      bit ok;
      ok = 1'b0;
      drive(d, z, s, sg);
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (in_ready_o) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid_i = 1'b0;
      chk("push_accept", 64'(ok), 64'd1);
   endtask

   // Single transaction on an idle pipe with out_ready high: checks the
   // two-cycle latency and the hand-computed result.
   task automatic send_chk(input string nm, input int d, input bit z,
                           input bit s, input logic [23:0] sg,
                           input int e_rsh, input logic [47:0] e_mask,
                           input logic [47:0] e_al, input bit e_st);
      drive(d, z, s, sg);
      @(negedge clk);
      chk({nm, "_ready"}, 64'(in_ready_o), 64'd1);
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      @(negedge clk);
      chk({nm, "_lat1"}, 64'(out_valid_o), 64'd0);
      @(negedge clk);
      chk({nm, "_lat2"}, 64'(out_valid_o), 64'd1);
      chk({nm, "_rsh"}, 64'(rsh_amt_o), 64'(e_rsh));
      chk({nm, "_mask"}, 64'(lost_bits_mask_o), 64'(e_mask));
      chk({nm, "_al"}, 64'(sig_aligned_o), 64'(e_al));
      chk({nm, "_st"}, 64'(sticky_o), 64'(e_st));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         @(negedge clk);
         if (!out_valid_o && q.size() == 0) done = 1'b1;
      end
      chk({nm, "_drained"}, 64'(done), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      rst_n       = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      drive(0, 1'b0, 1'b0, 24'h0);
      in_valid_i  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      chk("rst_rsh", 64'(rsh_amt_o), 64'd0);
      chk("rst_mask", 64'(lost_bits_mask_o), 64'd0);
      chk("rst_al", 64'(sig_aligned_o), 64'd0);
      chk("rst_st", 64'(sticky_o), 64'd0);
      @(posedge clk);
      #1;

      // Pin the reference model itself.
      begin
         exp_t e;
         e = model(30, 1'b0, 1'b1, 24'h800001);
         chk("model_rsh", 64'(e.rsh), 64'd29);
         chk("model_al", 64'(e.al), 64'h000000040000);
         e = model(1, 1'b1, 1'b1, 24'h0000FF);
         chk("model_neg", 64'(e.rsh), 64'd0);
      end

      send_chk("t1", 3, 1'b0, 1'b0, 24'h800001,
               3, 48'h000000000007, 48'h100000200000, 1'b0);
      send_chk("t2", 30, 1'b0, 1'b1, 24'h800001,
               29, 48'h00001FFFFFFF, 48'h000000040000, 1'b1);
      send_chk("t3", 200, 1'b0, 1'b0, 24'h000001,
               48, 48'hFFFFFFFFFFFF, 48'h0, 1'b1);
      send_chk("t3z", 200, 1'b0, 1'b0, 24'h000000,
               48, 48'hFFFFFFFFFFFF, 48'h0, 1'b0);
      send_chk("t3e", 48, 1'b0, 1'b0, 24'h800000,
               48, 48'hFFFFFFFFFFFF, 48'h0, 1'b1);
      send_chk("t3f", 49, 1'b0, 1'b1, 24'h800000,
               48, 48'hFFFFFFFFFFFF, 48'h0, 1'b1);
      send_chk("t4", 1, 1'b1, 1'b1, 24'h800001,
               0, 48'h0, 48'h800001000000, 1'b0);
      for (int f = 0; f < 4; f++) begin
         send_chk("t4d0", 0, f[0], f[1], 24'hABCDEF,
                  0, 48'h0, 48'hABCDEF000000, 1'b0);
      end

      // Back-to-back stream, full throughput.
      for (int i = 0; i < 6; i++)
         push(5 * i, i[0], i[1], 24'h9A5C31 ^ 24'(i * 24'h111111));
      drain("stream");

      // Backpressure: out_ready low for 5 cycles.
      n0 = n_out;
      out_ready_i = 1'b0;
      fork
         begin
            for (int i = 1; i <= 4; i++)
               push(i, 1'b0, 1'b0, 24'hFFFFFF);
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready_o), 64'd0);
            chk("bp_out_valid", 64'(out_valid_o), 64'd1);
            chk("bp_rsh", 64'(rsh_amt_o), 64'd1);
            chk("bp_al", 64'(sig_aligned_o), 64'h7FFFFF800000);
            repeat (2) @(posedge clk);
            #1;
            out_ready_i = 1'b1;
         end
      join
      drain("bp");
      chk("bp_count", 64'(n_out - n0), 64'd4);

      // Reset with both stages full.
      out_ready_i = 1'b0;
      push(7, 1'b0, 1'b0, 24'h123456);
      push(8, 1'b0, 1'b0, 24'h654321);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk);
      chk("mrst_out_valid", 64'(out_valid_o), 64'd0);
      chk("mrst_in_ready", 64'(in_ready_o), 64'd1);
      @(posedge clk);
      #1;
      send_chk("t6", 5, 1'b0, 1'b0, 24'hC00000,
               5, 48'h00000000001F, 48'h060000000000, 1'b0);
      drain("end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
